// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver running entirely in the clk domain.
// The raw PS/2 lines are synchronised and the clock line is de-glitched.
// Falling edges of the filtered clock step a start/data/parity/stop deframer.
// Good bytes land in a first-word fall-through FIFO with a valid/ready pop.
// Parity, frame, timeout and overflow problems are reported as registered
// one-cycle error pulses.
module ps2_rx_fifo #(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 1,     // 0 none, 1 odd, 2 even
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 5000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          err_parity,
    output logic                          err_frame,
    output logic                          err_timeout,
    output logic                          err_overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [3:0]    FLT_LAST = 4'(FILTER_LEN - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [1:0] clk_sync_q;
    logic [1:0] data_sync_q;
    logic       clk_s;
    logic       data_s;

    logic       clk_f_q,   clk_f_d;
    logic [3:0] flt_cnt_q, flt_cnt_d;
    logic       fall_q,    fall_d;

    assign clk_s  = clk_sync_q[1];
    assign data_s = data_sync_q[1];

    // Two-flop synchronisers; both lines idle high, so reset to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop
            // samples the pre-edge values, which is what makes a shift chain work.
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
        end
    end

    // Glitch filter: clk_f follows clk_s only after FILTER_LEN differing samples in a row.
    always_comb begin
        // NOTE: every combinational output gets a default first; a path that
        // leaves a signal unassigned would otherwise infer a latch.
        clk_f_d   = clk_f_q;
        flt_cnt_d = '0;
        if (clk_s != clk_f_q) begin
            if (flt_cnt_q == FLT_LAST) begin
                clk_f_d = clk_s;
            end else begin
                flt_cnt_d = flt_cnt_q + 4'd1;
            end
        end
        fall_d = clk_f_q & ~clk_f_d;
    end

    // Filter state and the registered falling-edge strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_f_q   <= 1'b1;
            flt_cnt_q <= '0;
            fall_q    <= 1'b0;
        end else begin
            clk_f_q   <= clk_f_d;
            flt_cnt_q <= flt_cnt_d;
            fall_q    <= fall_d;
        end
    end

    // ------------------------------------------------------------------
    // Deframer FSM, timeout and error pulses
    // ------------------------------------------------------------------
    state_t                state_q,   state_d;
    logic [DATA_BITS-1:0]  shift_q,   shift_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  par_ok_q,  par_ok_d;
    logic [TW-1:0]         to_cnt_q,  to_cnt_d;
    logic                  err_par_q, err_par_d;
    logic                  err_frm_q, err_frm_d;
    logic                  err_to_q,  err_to_d;
    logic                  err_ovf_q, err_ovf_d;
    logic                  timeout;
    logic                  par_calc;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic [CW-1:0]         count_q;

    assign full    = (count_q == CNT_FULL);
    assign timeout = (state_q != S_IDLE) && (to_cnt_q == TO_LAST);

    // Next state, shift/parity bookkeeping and error decisions; timeout beats a coincident fall.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        par_ok_d  = par_ok_q;
        err_par_d = 1'b0;
        err_frm_d = 1'b0;
        err_to_d  = 1'b0;
        err_ovf_d = 1'b0;
        push      = 1'b0;
        par_calc  = ^shift_q ^ data_s;

        if (timeout) begin
            err_to_d = 1'b1;
            state_d  = S_IDLE;
        end else if (fall_q) begin
            case (state_q)
                S_IDLE: begin
                    if (!data_s) begin
                        shift_d   = '0;
                        bit_cnt_d = '0;
                        par_ok_d  = 1'b1;
                        state_d   = S_DATA;
                    end
                end
                S_DATA: begin
                    shift_d   = {data_s, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = (PARITY_MODE == 0) ? S_STOP : S_PARITY;
                    end
                end
                S_PARITY: begin
                    par_ok_d = (PARITY_MODE == 2) ? ~par_calc : par_calc;
                    state_d  = S_STOP;
                end
                S_STOP: begin
                    if (!data_s) begin
                        err_frm_d = 1'b1;
                    end else if (!par_ok_q) begin
                        err_par_d = 1'b1;
                    end else if (full && !pop) begin
                        err_ovf_d = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (state_q == S_IDLE || fall_q || timeout) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    // FSM, timeout counter and error pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            par_ok_q  <= 1'b1;
            to_cnt_q  <= '0;
            err_par_q <= 1'b0;
            err_frm_q <= 1'b0;
            err_to_q  <= 1'b0;
            err_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            par_ok_q  <= par_ok_d;
            to_cnt_q  <= to_cnt_d;
            err_par_q <= err_par_d;
            err_frm_q <= err_frm_d;
            err_to_q  <= err_to_d;
            err_ovf_q <= err_ovf_d;
        end
    end

    assign err_parity   = err_par_q;
    assign err_frame    = err_frm_q;
    assign err_timeout  = err_to_q;
    assign err_overflow = err_ovf_q;

    // ------------------------------------------------------------------
    // Output FIFO (first-word fall-through)
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q;
    logic [AW-1:0]        rd_ptr_q;

    assign rx_valid = (count_q != '0);
    assign pop      = rx_valid & rx_ready;
    assign rx_count = count_q;
    assign rx_data  = rx_valid ? mem_q[rd_ptr_q] : '0;

    // Storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; reads are masked while empty,
        // so stale contents are never visible and the array can map to RAM.
        if (push) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    // Pointers wrap naturally at FIFO_DEPTH; push and pop together leave count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: drives PS/2 frames bit by bit and compares
// error pulses, occupancy and FIFO contents against a queue-based model.
module tb_ps2_rx_fifo;

    localparam int DB    = 8;
    localparam int FL    = 4;
    localparam int TO    = 200;
    localparam int DEPTH = 4;
    localparam int HALF  = 15;     // clk cycles per PS/2 clock half period

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rx_ready = 1'b0;
    logic       rx2_ready = 1'b0;
    logic [7:0] rx_data,  rx2_data;
    logic       rx_valid, rx2_valid;
    logic [2:0] rx_count, rx2_count;
    logic       err_parity, err_frame, err_timeout, err_overflow;
    logic       e2_par, e2_frm, e2_to, e2_ovf;

    int checks = 0;
    int errors = 0;

    logic [7:0] model_q [$];
    logic [7:0] model_pop;
    logic [7:0] pop_seen;
    int         n_err [4];
    int         snap [4];
    logic [3:0] err_prev = 4'b0;
    int         err_wide = 0;

    always #5 clk = ~clk;

    ps2_rx_fifo #(.DATA_BITS(DB), .PARITY_MODE(1), .FILTER_LEN(FL),
                  .TIMEOUT_CYC(TO), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_count(rx_count), .err_parity(err_parity), .err_frame(err_frame),
        .err_timeout(err_timeout), .err_overflow(err_overflow));

    ps2_rx_fifo #(.DATA_BITS(DB), .PARITY_MODE(2), .FILTER_LEN(FL),
                  .TIMEOUT_CYC(TO), .FIFO_DEPTH(DEPTH)) dut_even (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rx_data(rx2_data), .rx_valid(rx2_valid), .rx_ready(rx2_ready),
        .rx_count(rx2_count), .err_parity(e2_par), .err_frame(e2_frm),
        .err_timeout(e2_to), .err_overflow(e2_ovf));

    // Error pulse monitor: counts pulses per type ({ovf,to,frame,par}) and flags any pulse wider than one cycle.
    always @(negedge clk) begin
        logic [3:0] e;
        e = {err_overflow, err_timeout, err_frame, err_parity};
        if ((e & err_prev) != 4'b0) err_wide++;
        for (int i = 0; i < 4; i++) if (e[i]) n_err[i]++;
        err_prev = e;
    end

    task automatic snap_errs();
        for (int i = 0; i < 4; i++) snap[i] = n_err[i];
    endtask

    task automatic get_errs(output logic [3:0] v, output int tot);
        tot = 0;
        for (int i = 0; i < 4; i++) begin
            v[i] = (n_err[i] != snap[i]);
            tot += n_err[i] - snap[i];
        end
    endtask

    // One PS/2 bit: data set while the clock is high, then a low half period.
    task automatic drive_bit(input logic b, input logic glitch, input logic pop_here);
        @(negedge clk);
        ps2_data = b;
        if (glitch) begin
            repeat (5) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (FL - 1) @(negedge clk);
            ps2_clk = 1'b1;
        end
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        if (pop_here) begin
            // The deframer acts FL+2 edges after the raw fall; pop exactly on that edge.
            repeat (FL + 2) @(posedge clk);
            @(negedge clk);
            pop_seen = rx_data;
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                              input logic glitch, input logic pop_stop);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) drive_bit(bits[i], glitch && (i == 5), pop_stop && (i == 10));
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    // Reference model of one frame: returns the expected error vector {ovf,to,frame,par}.
    task automatic model_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                               input logic pop, output logic [3:0] exp);
        logic was_full;
        was_full = (model_q.size() == DEPTH);
        exp = 4'b0000;
        if (bad_stop)              exp = 4'b0010;
        else if (bad_par)          exp = 4'b0001;
        else if (was_full && !pop) exp = 4'b1000;
        if (pop && model_q.size() > 0) model_pop = model_q.pop_front();
        if (exp == 4'b0000) model_q.push_back(b);
    endtask

    task automatic run_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                             input logic glitch, input logic pop,
                             output logic [3:0] exp, output logic [3:0] got, output int tot);
        snap_errs();
        send_frame(b, bad_par, bad_stop, glitch, pop);
        model_frame(b, bad_par, bad_stop, pop, exp);
        get_errs(got, tot);
    endtask

    task automatic pop_one();
        @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        if (model_q.size() > 0) void'(model_q.pop_front());
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({rx_valid, rx_count, rx_data} !== 12'h000) begin
            errors++;
            $display("FAIL reset_fifo: valid=%b count=%0d data=%h want all 0", rx_valid, rx_count, rx_data);
        end
        checks++;
        if ({err_parity, err_frame, err_timeout, err_overflow} !== 4'b0) begin
            errors++;
            $display("FAIL reset_errs: %b%b%b%b want 0000", err_parity, err_frame, err_timeout, err_overflow);
        end
    endtask

    task automatic test_good_frame();
        logic [3:0] exp, got;
        int tot;
        run_frame(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0, exp, got, tot);
        checks++;
        if (got !== exp || tot !== ((exp != 0) ? 1 : 0)) begin
            errors++;
            $display("FAIL good_errs: got %b (%0d pulses) want %b", got, tot, exp);
        end
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h1C || rx_count !== 3'd1) begin
            errors++;
            $display("FAIL good_data: valid=%b data=%h count=%0d want 1 1c 1", rx_valid, rx_data, rx_count);
        end
        pop_one();
        checks++;
        if (rx_valid !== 1'b0 || rx_count !== 3'd0) begin
            errors++;
            $display("FAIL good_pop: valid=%b count=%0d want 0 0", rx_valid, rx_count);
        end
    endtask

    task automatic test_parity();
        logic [3:0] exp, got;
        int tot;
        run_frame(8'h1C, 1'b1, 1'b0, 1'b0, 1'b0, exp, got, tot);
        checks++;
        if (got !== exp || tot !== ((exp != 0) ? 1 : 0)) begin
            errors++;
            $display("FAIL parity_errs: got %b (%0d pulses) want %b", got, tot, exp);
        end
        checks++;
        if (rx_count !== 3'(model_q.size())) begin
            errors++;
            $display("FAIL parity_count: got %0d want %0d", rx_count, model_q.size());
        end
        // The even-parity instance saw the same frame with parity bit 1: accepted.
        checks++;
        if (rx2_valid !== 1'b1 || rx2_data !== 8'h1C || rx2_count !== 3'd1) begin
            errors++;
            $display("FAIL parity_even_accept: valid=%b data=%h count=%0d want 1 1c 1",
                     rx2_valid, rx2_data, rx2_count);
        end
        @(negedge clk);
        rx2_ready = 1'b1;
    endtask

    task automatic test_frame_error();
        logic [3:0] exp, got;
        int tot;
        run_frame(8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, exp, got, tot);
        checks++;
        if (got !== exp || tot !== ((exp != 0) ? 1 : 0) || rx_count !== 3'(model_q.size())) begin
            errors++;
            $display("FAIL frame_err: got %b (%0d pulses) count=%0d want %b count=%0d",
                     got, tot, rx_count, exp, model_q.size());
        end
        run_frame(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, exp, got, tot);
        checks++;
        if (got !== exp || rx_data !== 8'hF0 || rx_count !== 3'(model_q.size())) begin
            errors++;
            $display("FAIL frame_recover: errs %b data=%h count=%0d want %b f0 %0d",
                     got, rx_data, rx_count, exp, model_q.size());
        end
        pop_one();
    endtask

    task automatic test_glitch();
        logic [3:0] exp, got;
        int tot;
        run_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, exp, got, tot);
        checks++;
        if (got !== exp || tot !== 0 || rx_data !== 8'h5A || rx_count !== 3'd1) begin
            errors++;
            $display("FAIL glitch: errs %b data=%h count=%0d want %b 5a 1", got, rx_data, rx_count, exp);
        end
        pop_one();
    endtask

    task automatic test_timeout();
        logic [3:0] exp, got;
        int tot, n;
        logic seen;
        logic [7:0] b;
        b = 8'h12;
        snap_errs();
        drive_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive_bit(b[i], 1'b0, 1'b0);
        @(negedge clk);
        ps2_data = b[3];
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < FL + TO + 50) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == HALF) ps2_clk = 1'b1;
            if (err_timeout) seen = 1'b1;
        end
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        checks++;
        if (!seen || n !== FL + 3 + TO) begin
            errors++;
            $display("FAIL timeout_latency: seen=%b at %0d want %0d", seen, n, FL + 3 + TO);
        end
        repeat (5) @(negedge clk);
        get_errs(got, tot);
        checks++;
        if (got !== 4'b0100 || tot !== 1 || rx_count !== 3'd0) begin
            errors++;
            $display("FAIL timeout_errs: got %b (%0d pulses) count=%0d want 0100 0", got, tot, rx_count);
        end
        run_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b0, exp, got, tot);
        checks++;
        if (got !== exp || rx_data !== 8'h12 || rx_count !== 3'd1) begin
            errors++;
            $display("FAIL timeout_recover: errs %b data=%h count=%0d want %b 12 1", got, rx_data, rx_count, exp);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        b = 8'hA5;
        drive_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive_bit(b[i], 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rx_valid, rx_count, rx_data, err_parity, err_frame, err_timeout, err_overflow} !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid: valid=%b count=%0d data=%h errs=%b%b%b%b want all 0", rx_valid,
                     rx_count, rx_data, err_parity, err_frame, err_timeout, err_overflow);
        end
        model_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_overflow();
        logic [3:0] exp, got;
        int tot;
        for (int i = 1; i <= 5; i++) begin
            run_frame(8'(i), 1'b0, 1'b0, 1'b0, 1'b0, exp, got, tot);
            checks++;
            if (got !== exp || tot !== ((exp != 0) ? 1 : 0) || rx_count !== 3'(model_q.size())) begin
                errors++;
                $display("FAIL ovf_fill_%0d: errs %b count=%0d want %b %0d", i, got, rx_count, exp, model_q.size());
            end
        end
        // Push with a simultaneous pop while full: accepted, occupancy stays at DEPTH.
        run_frame(8'h06, 1'b0, 1'b0, 1'b0, 1'b1, exp, got, tot);
        checks++;
        if (got !== exp || pop_seen !== model_pop || rx_count !== 3'd4) begin
            errors++;
            $display("FAIL ovf_push_pop: errs %b popped=%h count=%0d want %b %h 4",
                     got, pop_seen, rx_count, exp, model_pop);
        end
        while (model_q.size() > 0) begin
            checks++;
            if (rx_valid !== 1'b1 || rx_data !== model_q[0]) begin
                errors++;
                $display("FAIL ovf_drain: valid=%b data=%h want 1 %h", rx_valid, rx_data, model_q[0]);
            end
            pop_one();
        end
    endtask

    task automatic test_random();
        logic [3:0] exp, got;
        int tot, kind, k;
        logic [7:0] b;
        for (int f = 0; f < 16; f++) begin
            b    = 8'($urandom);
            kind = $urandom_range(0, 9);
            run_frame(b, kind == 0, kind == 1, 1'b0, 1'b0, exp, got, tot);
            checks++;
            if (got !== exp || tot !== ((exp != 0) ? 1 : 0) || rx_count !== 3'(model_q.size())) begin
                errors++;
                $display("FAIL rand_frame_%0d: byte=%h errs %b (%0d) count=%0d want %b %0d",
                         f, b, got, tot, rx_count, exp, model_q.size());
            end
            k = $urandom_range(0, model_q.size());
            for (int j = 0; j < k; j++) begin
                checks++;
                if (rx_data !== model_q[0]) begin
                    errors++;
                    $display("FAIL rand_pop_%0d: data=%h want %h", f, rx_data, model_q[0]);
                end
                pop_one();
            end
        end
    endtask

    task automatic test_pulse_width();
        checks++;
        if (err_wide !== 0) begin
            errors++;
            $display("FAIL pulse_width: %0d multi-cycle error pulses want 0", err_wide);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        test_good_frame();
        test_parity();
        test_frame_error();
        test_glitch();
        test_timeout();
        test_reset_mid();
        test_overflow();
        test_random();
        test_pulse_width();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Parametrised PS/2 device-to-host receiver for the keyboard simulator. It replaces direct clocking on the PS/2 clock with a design that runs entirely in the system `clk` domain: it synchronises and de-glitches `ps2_clk`, detects falling edges, and deframes start/data/parity/stop. Good bytes go into an output FIFO with a valid/ready interface, and parity, frame, timeout and overflow conditions are reported as error pulses.

## Interface
- `DATA_BITS`, 8: data bits per frame, LSB first; legal range 5–9.
- `PARITY_MODE`, 1: 0 = no parity bit, 1 = odd (PS/2), 2 = even.
- `FILTER_LEN`, 4: consecutive equal samples needed before the filtered clock changes; legal range 1–15.
- `TIMEOUT_CYC`, 5000: clk cycles without a filtered falling edge before an in-progress frame is aborted (100 µs at 50 MHz).
- `FIFO_DEPTH`, 4: output FIFO entries; must be a power of 2, at least 2.
- `clk`, in, 1: system clock. All logic is on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `ps2_clk`, in, 1: raw PS/2 clock line (asynchronous).
- `ps2_data`, in, 1: raw PS/2 data line (asynchronous).
- `rx_data`, out, DATA_BITS: head of the FIFO (first-word fall-through).
- `rx_valid`, out, 1: FIFO is not empty.
- `rx_ready`, in, 1: consumer pop; a pop occurs when `rx_valid & rx_ready`.
- `rx_count`, out, clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `err_parity`, out, 1: one-cycle pulse on parity mismatch.
- `err_frame`, out, 1: one-cycle pulse when the stop bit is 0.
- `err_timeout`, out, 1: one-cycle pulse when a frame is aborted by timeout.
- `err_overflow`, out, 1: one-cycle pulse when a good frame arrives with the FIFO full.

## Operation
- Reset values:
  - all outputs are 0, including `rx_data` and `rx_count`;
  - FSM is in IDLE;
  - synchronisers and the filtered clock reset to 1, which is the idle line level;
  - FIFO pointers are 0.
- Input conditioning:
  - Each raw line passes through a 2-flop synchroniser.
  - Filter: `clk_f` takes the synchronised clock value only after FILTER_LEN consecutive identical samples that differ from `clk_f`. Any mismatching sample resets the filter counter.
  - `fall` = `clk_f` changed 1→0 this cycle.
- All FSM actions below occur only on `fall`. The sampled bit `d` is the synchronised `ps2_data` at that edge.
- FSM states:
  - **IDLE**: if `d`=0 (start bit), clear the shift register and `bit_cnt`, then go to DATA. If `d`=1, stay in IDLE with no error.
  - **DATA**: shift `d` in LSB first and increment `bit_cnt`. After DATA_BITS bits, go to PARITY, or to STOP when PARITY_MODE=0.
  - **PARITY**: `par_ok` = (^shift ^ `d`) == 1 for odd mode, == 0 for even mode. Go to STOP.
  - **STOP**, checks in priority order:
    1. `d`=0: pulse `err_frame`, discard the byte.
    2. else `!par_ok`: pulse `err_parity`, discard the byte.
    3. else FIFO full and no pop this cycle: pulse `err_overflow`, discard the byte; FIFO contents are unchanged.
    4. else push the byte.
    
    In every case, return to IDLE.
- Timeout:
  - The counter clears on every `fall` and whenever the FSM is in IDLE.
  - Outside IDLE it increments each cycle.
  - On reaching TIMEOUT_CYC: pulse `err_timeout`, go to IDLE, discard the partial byte.
  - A `fall` in the same cycle as the timeout is ignored, so the FSM resynchronises on the next start bit.
- FIFO:
  - Push and pop in the same cycle are both performed, and `rx_count` is unchanged. When full, this makes room, so the push is accepted.
  - A pop while empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- The line state is never driven; this block is receive-only.

## Timing
- Edge latency: a raw `ps2_clk` fall that is stable before clk edge 0 gives `clk_f`=0 after edge FILTER_LEN+1. `fall` is high in the following cycle, and the FSM acts at edge FILTER_LEN+2.
- Push to visibility: `rx_valid` rises and `rx_data` updates one cycle after the push edge.
- Pop: `rx_data` shows the next entry, or `rx_valid` drops, one cycle after the pop edge.
- All `err_*` outputs are exactly one clk cycle wide and registered. At most one `err_*` fires per frame.
- Reset mid-frame: the FSM returns to IDLE immediately and the FIFO empties. The remainder of the interrupted frame is treated as line noise: its bits are seen in IDLE with `d`=1 and ignored, or otherwise end in `err_frame`/`err_parity`/`err_timeout`.

## Test plan
- Good frame, defaults: start 0, data 0x1C LSB first, parity 0, stop 1, PS/2 clock period 80 µs → one push, `rx_data`=0x1C, `rx_valid`=1, no errors; pop clears `rx_valid`.
- Parity error: 0x1C frame with parity 1 → `err_parity` pulses once, `rx_count` stays 0. Repeat with PARITY_MODE=2 and parity 1 → accepted.
- Frame error: 0xF0 frame with stop bit 0 → `err_frame` pulse, nothing pushed. A following good 0xF0 frame is accepted.
- Glitch: a `ps2_clk` low pulse of FILTER_LEN-1 clk cycles mid-bit → no `fall`. The frame 0x5A still decodes correctly.
- Timeout and reset: stop clocking after 4 data bits → `err_timeout` exactly TIMEOUT_CYC cycles after the last `fall`, then the next frame 0x12 is accepted. Assert `rst_n`=0 mid-frame → all outputs 0 at once.
- Overflow: hold `rx_ready`=0 and send 0x01..0x05 → `rx_count`=4, `err_overflow` on the 5th frame. Pops then return 0x01..0x04 in order. A push and pop in the same cycle while full keeps `rx_count`=4.
